// File: rtl/ram8_stack_ctrl.sv
// ram8_stack_ctrl: 8-entry LIFO built on one external RAM8.
// Commands arrive on a valid/ready port and each gets exactly one response.
// The controller is the initiator on the mem_* port.
//
// Ports
//   clk, reset_n          clock, synchronous active-low reset
//   cmd_valid/cmd_ready   command handshake; cmd_op 00 PUSH 01 POP 10 PEEK 11 CLEAR
//   cmd_data              PUSH payload
//   rsp_valid/rsp_ready   response handshake; rsp_data/rsp_err held while stalled
//   mem_addr/mem_load/mem_in/mem_out   RAM8 port (mem_out is a combinational read)
//   depth, full, empty    occupancy, straight from the stack pointer
module ram8_stack_ctrl #(
    parameter int WIDTH  = 16,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [WIDTH-1:0]  cmd_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [WIDTH-1:0]  rsp_data,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_load,
    output logic [WIDTH-1:0]  mem_in,
    input  logic [WIDTH-1:0]  mem_out,
    output logic [ADDR_W:0]   depth,
    output logic              full,
    output logic              empty
);
    localparam logic [ADDR_W:0] DEPTH = (ADDR_W+1)'(2**ADDR_W);

    typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;
    typedef enum logic [1:0] {OP_PUSH = 2'd0, OP_POP = 2'd1, OP_PEEK = 2'd2, OP_CLEAR = 2'd3} op_t;

    state_t            state, next_state;
    op_t               op_q, cmd_op_e;
    logic [WIDTH-1:0]  data_q;
    logic [ADDR_W:0]   sp, sp_m1;
    logic              cmd_err;

    // One extra sp bit so "full" (sp==8) is distinct from "empty" (sp==0).
    assign depth    = sp;
    assign full     = (sp == DEPTH);
    assign empty    = (sp == '0);
    assign sp_m1    = sp - 1'b1;
    assign cmd_op_e = op_t'(cmd_op);
    assign cmd_err  = ((cmd_op_e == OP_PUSH) && full) ||
                      (((cmd_op_e == OP_POP) || (cmd_op_e == OP_PEEK)) && empty);

    always_ff @(posedge clk) begin
        if (!reset_n) state <= IDLE;
        else          state <= next_state;
    end

    always_comb begin
        next_state = state;
        cmd_ready  = 1'b0;
        rsp_valid  = 1'b0;
        mem_addr   = '0;
        mem_load   = 1'b0;
        mem_in     = '0;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                // Errors and CLEAR need no RAM access, so they skip EXEC.
                if (cmd_valid)
                    next_state = (cmd_err || (cmd_op_e == OP_CLEAR)) ? RESP : EXEC;
            end
            EXEC: begin
                next_state = RESP;
                if (op_q == OP_PUSH) begin
                    mem_addr = sp[ADDR_W-1:0];
                    mem_in   = data_q;
                    // Gated by reset so a reset during EXEC never lands a write.
                    mem_load = reset_n;
                end else begin
                    mem_addr = sp_m1[ADDR_W-1:0];
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sp       <= '0;
            rsp_data <= '0;
            rsp_err  <= 1'b0;
            data_q   <= '0;
            op_q     <= OP_PUSH;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        op_q     <= cmd_op_e;
                        data_q   <= cmd_data;
                        rsp_data <= '0;
                        rsp_err  <= cmd_err;
                        if (!cmd_err && (cmd_op_e == OP_CLEAR)) sp <= '0;
                    end
                end
                EXEC: begin
                    case (op_q)
                        OP_PUSH: sp <= sp + 1'b1;
                        OP_POP: begin
                            rsp_data <= mem_out;
                            sp       <= sp_m1;
                        end
                        OP_PEEK: rsp_data <= mem_out;
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_ram8_stack_ctrl.sv
module tb_ram8_stack_ctrl;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        cmd_valid = 1'b0, cmd_ready;
    logic [1:0]  cmd_op = 2'd0;
    logic [15:0] cmd_data = '0;
    logic        rsp_valid, rsp_ready = 1'b1;
    logic [15:0] rsp_data;
    logic        rsp_err;
    logic [2:0]  mem_addr;
    logic        mem_load;
    logic [15:0] mem_in, mem_out;
    logic [3:0]  depth;
    logic        full, empty;

    int n_cmp = 0, n_bad = 0, load_cnt = 0;
    logic [15:0] ram [8];

    ram8_stack_ctrl #(.WIDTH(16), .ADDR_W(3)) dut (
        .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_data(cmd_data), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_err(rsp_err), .mem_addr(mem_addr), .mem_load(mem_load),
        .mem_in(mem_in), .mem_out(mem_out), .depth(depth), .full(full), .empty(empty)
    );

    always #5 clk = ~clk;

    // RAM8 responder model: edge write, combinational read.
    always @(posedge clk) if (mem_load) ram[mem_addr] <= mem_in;
    assign mem_out = ram[mem_addr];
    always @(negedge clk) if (mem_load) load_cnt++;

    localparam logic [1:0] PUSH = 2'd0, POP = 2'd1, PEEK = 2'd2, CLEAR = 2'd3;

    // Issue one command with rsp_ready=1; lat = cycles from accept edge to rsp_valid.
    task automatic do_cmd(input logic [1:0] op, input logic [15:0] d,
                          output logic [15:0] rd, output logic re, output int lat);
        bit ok;
        rd = 'x; re = 1'bx; lat = -1;
        cmd_valid = 1'b1; cmd_op = op; cmd_data = d; rsp_ready = 1'b1;
        ok = 0;
        for (int i = 0; i < 10 && !ok; i++) begin
            @(negedge clk);
            if (cmd_ready) ok = 1;
            @(posedge clk); #1;
        end
        cmd_valid = 1'b0;
        n_cmp++;
        if (!ok) begin n_bad++; $display("FAIL accept_timeout op=%0d", op); return; end
        ok = 0;
        for (int i = 0; i < 10 && !ok; i++) begin
            @(negedge clk);
            if (rsp_valid) begin ok = 1; lat = i; rd = rsp_data; re = rsp_err; end
            @(posedge clk); #1;
        end
        n_cmp++;
        if (!ok) begin n_bad++; $display("FAIL rsp_timeout op=%0d", op); end
    endtask

    task automatic do_reset();
        reset_n = 1'b0; cmd_valid = 1'b0; rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL rst_rsp_valid got=%b exp=0", rsp_valid); end
        n_cmp++; if (rsp_data !== 16'h0) begin n_bad++; $display("FAIL rst_rsp_data got=%h exp=0", rsp_data); end
        n_cmp++; if (rsp_err !== 1'b0) begin n_bad++; $display("FAIL rst_rsp_err got=%b exp=0", rsp_err); end
        n_cmp++; if (depth !== 4'd0 || empty !== 1'b1 || full !== 1'b0) begin n_bad++; $display("FAIL rst_depth got=%0d/%b/%b exp=0/1/0", depth, empty, full); end
        n_cmp++; if (mem_load !== 1'b0) begin n_bad++; $display("FAIL rst_mem_load got=%b exp=0", mem_load); end
        @(posedge clk); #1 reset_n = 1'b1;
        @(negedge clk);
        n_cmp++; if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL rst_cmd_ready got=%b exp=1", cmd_ready); end
        @(posedge clk); #1;
    endtask

    task automatic test_push_pop();
        logic [15:0] rd; logic re; int lat;
        logic [15:0] w [3];
        w[0] = 16'h1111; w[1] = 16'h2222; w[2] = 16'h3333;
        for (int i = 0; i < 3; i++) begin
            do_cmd(PUSH, w[i], rd, re, lat);
            n_cmp++; if (re !== 1'b0 || rd !== 16'h0 || lat != 1) begin n_bad++; $display("FAIL push%0d got err=%b data=%h lat=%0d exp 0/0000/1", i, re, rd, lat); end
        end
        n_cmp++; if (depth !== 4'd3) begin n_bad++; $display("FAIL pp_depth got=%0d exp=3", depth); end
        for (int i = 2; i >= 0; i--) begin
            do_cmd(POP, 16'h0, rd, re, lat);
            n_cmp++; if (re !== 1'b0 || rd !== w[i] || lat != 1) begin n_bad++; $display("FAIL pop%0d got err=%b data=%h lat=%0d exp 0/%h/1", i, re, rd, lat, w[i]); end
        end
        n_cmp++; if (empty !== 1'b1 || depth !== 4'd0) begin n_bad++; $display("FAIL pp_empty got=%b/%0d exp=1/0", empty, depth); end
    endtask

    task automatic test_empty_err();
        logic [15:0] rd; logic re; int lat;
        do_reset();
        do_cmd(POP, 16'h0, rd, re, lat);
        n_cmp++; if (re !== 1'b1 || rd !== 16'h0 || lat != 0) begin n_bad++; $display("FAIL pop_empty got err=%b data=%h lat=%0d exp 1/0000/0", re, rd, lat); end
        do_cmd(PEEK, 16'h0, rd, re, lat);
        n_cmp++; if (re !== 1'b1 || rd !== 16'h0 || lat != 0) begin n_bad++; $display("FAIL peek_empty got err=%b data=%h lat=%0d exp 1/0000/0", re, rd, lat); end
        n_cmp++; if (depth !== 4'd0) begin n_bad++; $display("FAIL empty_depth got=%0d exp=0", depth); end
    endtask

    task automatic test_full();
        logic [15:0] rd; logic re; int lat, lc;
        for (int i = 0; i < 8; i++) do_cmd(PUSH, 16'hC000 + 16'(i), rd, re, lat);
        n_cmp++; if (full !== 1'b1 || depth !== 4'd8 || empty !== 1'b0) begin n_bad++; $display("FAIL full_flag got=%b/%0d exp=1/8", full, depth); end
        lc = load_cnt;
        do_cmd(PUSH, 16'hDEAD, rd, re, lat);
        n_cmp++; if (re !== 1'b1 || rd !== 16'h0 || lat != 0) begin n_bad++; $display("FAIL push_full got err=%b data=%h lat=%0d exp 1/0000/0", re, rd, lat); end
        n_cmp++; if (load_cnt != lc) begin n_bad++; $display("FAIL push_full_load got=%0d exp=0 writes", load_cnt - lc); end
        n_cmp++; if (depth !== 4'd8) begin n_bad++; $display("FAIL push_full_depth got=%0d exp=8", depth); end
        do_cmd(POP, 16'h0, rd, re, lat);
        n_cmp++; if (re !== 1'b0 || rd !== 16'hC007 || depth !== 4'd7) begin n_bad++; $display("FAIL pop_top got err=%b data=%h depth=%0d exp 0/c007/7", re, rd, depth); end
    endtask

    task automatic test_clear();
        logic [15:0] rd; logic re; int lat, lc;
        do_cmd(CLEAR, 16'h0, rd, re, lat);
        for (int i = 0; i < 3; i++) do_cmd(PUSH, 16'h7000 + 16'(i), rd, re, lat);
        n_cmp++; if (depth !== 4'd3) begin n_bad++; $display("FAIL clr_pre_depth got=%0d exp=3", depth); end
        lc = load_cnt;
        do_cmd(CLEAR, 16'hFFFF, rd, re, lat);
        n_cmp++; if (re !== 1'b0 || rd !== 16'h0 || lat != 0) begin n_bad++; $display("FAIL clear_rsp got err=%b data=%h lat=%0d exp 0/0000/0", re, rd, lat); end
        n_cmp++; if (depth !== 4'd0 || empty !== 1'b1 || load_cnt != lc) begin n_bad++; $display("FAIL clear_state got depth=%0d empty=%b writes=%0d exp 0/1/0", depth, empty, load_cnt - lc); end
        do_cmd(POP, 16'h0, rd, re, lat);
        n_cmp++; if (re !== 1'b1) begin n_bad++; $display("FAIL clear_pop got err=%b exp=1", re); end
    endtask

    // cmd_valid held high: a legal command is accepted every 3 cycles.
    task automatic test_back_to_back();
        cmd_valid = 1'b1; cmd_op = PUSH; cmd_data = 16'h5555; rsp_ready = 1'b1;
        repeat (6) @(posedge clk);
        #1 cmd_valid = 1'b0;
        @(negedge clk);
        n_cmp++; if (depth !== 4'd2) begin n_bad++; $display("FAIL b2b_depth got=%0d exp=2", depth); end
        n_cmp++; if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_idle got=%b exp=1", cmd_ready); end
        @(posedge clk); #1;
    endtask

    task automatic test_peek_hold();
        logic [15:0] rd; logic re; int lat;
        do_cmd(CLEAR, 16'h0, rd, re, lat);
        do_cmd(PUSH, 16'hBEEF, rd, re, lat);
        cmd_valid = 1'b1; cmd_op = PEEK; rsp_ready = 1'b0;
        @(negedge clk); @(posedge clk); #1 cmd_valid = 1'b0;
        @(negedge clk); @(posedge clk); #1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_cmp++; if (rsp_valid !== 1'b1 || rsp_data !== 16'hBEEF || rsp_err !== 1'b0 || cmd_ready !== 1'b0)
                begin n_bad++; $display("FAIL peek_hold%0d got v=%b d=%h e=%b rdy=%b exp 1/beef/0/0", i, rsp_valid, rsp_data, rsp_err, cmd_ready); end
            @(posedge clk); #1;
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        n_cmp++; if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || depth !== 4'd1) begin n_bad++; $display("FAIL peek_release got v=%b rdy=%b depth=%0d exp 0/1/1", rsp_valid, cmd_ready, depth); end
        @(posedge clk); #1;
    endtask

    // depth=1 here, so the aborted PUSH would have targeted ram[1] (holds 0x5555).
    task automatic test_reset_exec();
        cmd_valid = 1'b1; cmd_op = PUSH; cmd_data = 16'hAAAA;
        @(negedge clk); @(posedge clk); #1;
        cmd_valid = 1'b0; reset_n = 1'b0;
        @(negedge clk);
        n_cmp++; if (mem_load !== 1'b0) begin n_bad++; $display("FAIL rstexec_load got=%b exp=0", mem_load); end
        @(posedge clk); #1 reset_n = 1'b1;
        @(negedge clk);
        n_cmp++; if (depth !== 4'd0 || rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin n_bad++; $display("FAIL rstexec_state got depth=%0d v=%b rdy=%b exp 0/0/1", depth, rsp_valid, cmd_ready); end
        n_cmp++; if (ram[1] !== 16'h5555) begin n_bad++; $display("FAIL rstexec_ram got=%h exp=5555", ram[1]); end
        @(posedge clk); #1;
    endtask

    initial begin
        for (int i = 0; i < 8; i++) ram[i] = '0;
        test_reset();
        test_push_pop();
        test_empty_err();
        test_full();
        test_clear();
        test_back_to_back();
        test_peek_hold();
        test_reset_exec();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
